// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline stall/flush sequencer with multi-cycle execute tracking
module pipe_ctrl #(
  parameter int CNT_W  = 6,
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallreq_id_i,
  input  logic              mc_start_i,
  input  logic [CNT_W-1:0]  mc_cycles_i,
  input  logic              mc_cancel_i,
  input  logic              flush_req_i,
  input  logic [31:0]       flush_pc_i,
  output logic [5:0]        stall_o,
  output logic              flush_o,
  output logic [31:0]       new_pc_o,
  output logic              mc_busy_o,
  output logic              mc_done_o,
  output logic [PERF_W-1:0] stall_cnt_o
);

  typedef enum logic {
    IDLE   = 1'b0,
    MC_RUN = 1'b1
  } state_t;

  localparam logic [5:0] STALL_LU = 6'b000111;
  localparam logic [5:0] STALL_MC = 6'b001111;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  ne;
  logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [5:0]        stall;
  logic              flush;
  logic              done;
  logic [31:0]       new_pc;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    stall       = 6'b000000;
    flush       = 1'b0;
    done        = 1'b0;
    new_pc      = 32'h0;
    ne          = (mc_cycles_i == '0) ? CNT_W'(1) : mc_cycles_i;

    if (flush_req_i) begin
      flush   = 1'b1;
      new_pc  = flush_pc_i;
      state_d = IDLE;
      cnt_d   = '0;
    end else if (state_q == MC_RUN) begin
      if (mc_cancel_i) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else if (cnt_q == CNT_W'(1)) begin
        done    = 1'b1;
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        stall = STALL_MC;
        cnt_d = cnt_q - CNT_W'(1);
      end
    end else if (mc_start_i && ne != CNT_W'(1)) begin
      stall   = STALL_MC;
      cnt_d   = ne - CNT_W'(1);
      state_d = MC_RUN;
    end else begin
      // single-cycle ops complete in place and still honour the load-use interlock
      done  = mc_start_i;
      stall = stallreq_id_i ? STALL_LU : 6'b000000;
    end

    stall_cnt_d = (stall != 6'b000000) ? stall_cnt_q + PERF_W'(1) : stall_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_o     = rst ? 6'b000000 : stall;
  assign flush_o     = !rst && flush;
  assign new_pc_o    = rst ? 32'h0 : new_pc;
  assign mc_done_o   = !rst && done;
  assign mc_busy_o   = !rst && (state_q == MC_RUN);
  assign stall_cnt_o = rst ? '0 : stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed vector table plus randomized run against a cycle-indexed model
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst, stallreq_id_i, mc_start_i, mc_cancel_i, flush_req_i;
  logic [5:0]  mc_cycles_i;
  logic [31:0] flush_pc_i;
  logic [5:0]  stall_o;
  logic        flush_o, mc_busy_o, mc_done_o;
  logic [31:0] new_pc_o;
  logic [31:0] stall_cnt_o;

  pipe_ctrl #(.CNT_W(6), .PERF_W(32)) dut (
    .clk(clk), .rst(rst), .stallreq_id_i(stallreq_id_i), .mc_start_i(mc_start_i),
    .mc_cycles_i(mc_cycles_i), .mc_cancel_i(mc_cancel_i), .flush_req_i(flush_req_i),
    .flush_pc_i(flush_pc_i), .stall_o(stall_o), .flush_o(flush_o), .new_pc_o(new_pc_o),
    .mc_busy_o(mc_busy_o), .mc_done_o(mc_done_o), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, sreq, start;
    logic [5:0]  n;
    logic        cancel, flush;
    logic [31:0] fpc;
    logic [5:0]  e_stall;
    logic        e_flush;
    logic [31:0] e_pc;
    logic        e_busy, e_done;
    int          e_perf;
  } vec_t;

  vec_t vecs[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;

  // model: an op is remembered by the absolute cycle in which its result lands
  int          cyc = 0;
  bit          in_op = 0;
  int          end_cyc = 0;
  logic [31:0] perf = 0;
  logic [5:0]  m_stall;
  logic        m_flush, m_busy, m_done;
  logic [31:0] m_pc, m_perf;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
  endtask

  task automatic add(input logic r, sr, st, input logic [5:0] n, input logic cn, fl,
                     input logic [31:0] pc, input logic [5:0] es, input logic ef,
                     input logic [31:0] ep, input logic eb, ed, input int eperf);
    vec_t v;
    v.rst = r; v.sreq = sr; v.start = st; v.n = n; v.cancel = cn; v.flush = fl; v.fpc = pc;
    v.e_stall = es; v.e_flush = ef; v.e_pc = ep; v.e_busy = eb; v.e_done = ed; v.e_perf = eperf;
    vecs.push_back(v);
  endtask

  task automatic run_cycle(input logic r, sr, st, input logic [5:0] n, input logic cn, fl,
                           input logic [31:0] pc);
    bit next_op;
    int ne;
    @(negedge clk);
    rst = r; stallreq_id_i = sr; mc_start_i = st; mc_cycles_i = n;
    mc_cancel_i = cn; flush_req_i = fl; flush_pc_i = pc;
    #1;
    m_stall = 0; m_flush = 0; m_pc = 0; m_done = 0; m_busy = 0; m_perf = 0;
    next_op = in_op;
    ne = (n == 0) ? 1 : int'(n);
    if (!r) begin
      m_busy = in_op;
      m_perf = perf;
      if (fl) begin
        m_flush = 1; m_pc = pc; next_op = 0;
      end else if (in_op) begin
        if (cn) next_op = 0;
        else if (cyc == end_cyc) begin m_done = 1; next_op = 0; end
        else m_stall = 6'b001111;
      end else if (st && ne >= 2) begin
        m_stall = 6'b001111; next_op = 1; end_cyc = cyc + ne - 1;
      end else begin
        m_done  = st;
        m_stall = sr ? 6'b000111 : 6'b000000;
      end
    end
    chk("stall_o", 64'(stall_o), 64'(m_stall));
    chk("flush_o", 64'(flush_o), 64'(m_flush));
    chk("new_pc_o", 64'(new_pc_o), 64'(m_pc));
    chk("mc_busy_o", 64'(mc_busy_o), 64'(m_busy));
    chk("mc_done_o", 64'(mc_done_o), 64'(m_done));
    chk("stall_cnt_o", 64'(stall_cnt_o), 64'(m_perf));
    if (r) begin
      in_op = 0; perf = 0;
    end else begin
      in_op = next_op;
      if (m_stall != 0) perf = perf + 1;
    end
    cyc++;
  endtask

  initial begin
    rst = 1; stallreq_id_i = 0; mc_start_i = 0; mc_cycles_i = 0;
    mc_cancel_i = 0; flush_req_i = 0; flush_pc_i = 0;

    //   rst sr st n   cn fl pc        stall      fl e_pc      bsy dn perf
    add(1, 0, 1, 10, 0, 0, 32'h0,   6'b000000, 0, 32'h0,   0, 0, 0);
    add(0, 0, 0, 0,  0, 0, 32'h0,   6'b000000, 0, 32'h0,   0, 0, 0);
    add(0, 1, 0, 0,  0, 0, 32'h0,   6'b000111, 0, 32'h0,   0, 0, 0);
    add(0, 1, 0, 0,  0, 0, 32'h0,   6'b000111, 0, 32'h0,   0, 0, 1);
    add(0, 0, 0, 0,  0, 0, 32'h0,   6'b000000, 0, 32'h0,   0, 0, 2);
    add(0, 0, 1, 4,  0, 0, 32'h0,   6'b001111, 0, 32'h0,   0, 0, 2);
    add(0, 0, 0, 0,  0, 0, 32'h0,   6'b001111, 0, 32'h0,   1, 0, 3);
    add(0, 0, 0, 0,  0, 0, 32'h0,   6'b001111, 0, 32'h0,   1, 0, 4);
    add(0, 0, 1, 3,  0, 0, 32'h0,   6'b000000, 0, 32'h0,   1, 1, 5);
    add(0, 0, 0, 0,  0, 0, 32'h0,   6'b000000, 0, 32'h0,   0, 0, 5);
    add(0, 0, 1, 0,  0, 0, 32'h0,   6'b000000, 0, 32'h0,   0, 1, 5);
    add(0, 1, 1, 1,  0, 0, 32'h0,   6'b000111, 0, 32'h0,   0, 1, 5);
    add(0, 0, 0, 0,  0, 0, 32'h0,   6'b000000, 0, 32'h0,   0, 0, 6);
    add(0, 0, 1, 8,  0, 0, 32'h0,   6'b001111, 0, 32'h0,   0, 0, 6);
    add(0, 0, 0, 0,  0, 0, 32'h0,   6'b001111, 0, 32'h0,   1, 0, 7);
    add(0, 0, 0, 0,  0, 0, 32'h0,   6'b001111, 0, 32'h0,   1, 0, 8);
    add(0, 0, 0, 0,  0, 1, 32'h180, 6'b000000, 1, 32'h180, 1, 0, 9);
    add(0, 0, 0, 0,  0, 0, 32'h0,   6'b000000, 0, 32'h0,   0, 0, 9);
    add(0, 0, 1, 6,  0, 0, 32'h0,   6'b001111, 0, 32'h0,   0, 0, 9);
    add(0, 0, 0, 0,  0, 0, 32'h0,   6'b001111, 0, 32'h0,   1, 0, 10);
    add(0, 0, 0, 0,  1, 0, 32'h0,   6'b000000, 0, 32'h0,   1, 0, 11);
    add(0, 0, 0, 0,  0, 0, 32'h0,   6'b000000, 0, 32'h0,   0, 0, 11);
    add(0, 1, 1, 5,  0, 0, 32'h0,   6'b001111, 0, 32'h0,   0, 0, 11);
    add(0, 1, 0, 0,  0, 0, 32'h0,   6'b001111, 0, 32'h0,   1, 0, 12);
    add(0, 0, 0, 0,  0, 0, 32'h0,   6'b001111, 0, 32'h0,   1, 0, 13);
    add(0, 0, 0, 0,  0, 0, 32'h0,   6'b001111, 0, 32'h0,   1, 0, 14);
    add(0, 0, 0, 0,  0, 0, 32'h0,   6'b000000, 0, 32'h0,   1, 1, 15);
    add(0, 0, 0, 0,  0, 0, 32'h0,   6'b000000, 0, 32'h0,   0, 0, 15);
    add(0, 0, 1, 2,  0, 0, 32'h0,   6'b001111, 0, 32'h0,   0, 0, 15);
    add(0, 0, 0, 0,  0, 1, 32'h40,  6'b000000, 1, 32'h40,  1, 0, 16);
    add(0, 0, 0, 0,  0, 0, 32'h0,   6'b000000, 0, 32'h0,   0, 0, 16);
    add(0, 0, 1, 3,  0, 0, 32'h0,   6'b001111, 0, 32'h0,   0, 0, 16);
    add(0, 0, 0, 0,  1, 1, 32'h44,  6'b000000, 1, 32'h44,  1, 0, 17);
    add(0, 0, 0, 0,  0, 0, 32'h0,   6'b000000, 0, 32'h0,   0, 0, 17);
    add(0, 1, 1, 5,  0, 1, 32'h88,  6'b000000, 1, 32'h88,  0, 0, 17);
    add(0, 0, 0, 0,  0, 0, 32'h0,   6'b000000, 0, 32'h0,   0, 0, 17);
    add(0, 0, 1, 10, 0, 0, 32'h0,   6'b001111, 0, 32'h0,   0, 0, 17);
    add(0, 0, 0, 0,  0, 0, 32'h0,   6'b001111, 0, 32'h0,   1, 0, 18);
    add(0, 0, 0, 0,  0, 0, 32'h0,   6'b001111, 0, 32'h0,   1, 0, 19);
    add(0, 0, 0, 0,  0, 0, 32'h0,   6'b001111, 0, 32'h0,   1, 0, 20);
    add(1, 0, 0, 0,  0, 0, 32'h0,   6'b000000, 0, 32'h0,   0, 0, 0);
    add(0, 0, 0, 0,  0, 0, 32'h0,   6'b000000, 0, 32'h0,   0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      run_cycle(vecs[i].rst, vecs[i].sreq, vecs[i].start, vecs[i].n,
                vecs[i].cancel, vecs[i].flush, vecs[i].fpc);
      chk($sformatf("vec%0d.stall", i), 64'(stall_o), 64'(vecs[i].e_stall));
      chk($sformatf("vec%0d.flush", i), 64'(flush_o), 64'(vecs[i].e_flush));
      chk($sformatf("vec%0d.new_pc", i), 64'(new_pc_o), 64'(vecs[i].e_pc));
      chk($sformatf("vec%0d.busy", i), 64'(mc_busy_o), 64'(vecs[i].e_busy));
      chk($sformatf("vec%0d.done", i), 64'(mc_done_o), 64'(vecs[i].e_done));
      chk($sformatf("vec%0d.perf", i), 64'(stall_cnt_o), 64'(vecs[i].e_perf));
    end

    for (int i = 0; i < 3000; i++) begin
      logic [5:0] rn;
      rn = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 6));
      run_cycle($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 3,
                $urandom_range(0, 9) < 2, rn, $urandom_range(0, 19) == 0,
                $urandom_range(0, 29) == 0, $urandom);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
